seq_data_mux: RTL and testbench

- Registered sequencing multiplexer. Presents one of NUM_CH input channels on a single output.
- Steps to the next enabled channel on each rising edge of a slow, clock-synchronous `advance` strobe, in round-robin order with wrap-around.
- Used wherever a stage replays a fixed set of stored operand or pattern words one at a time (for example, stage-by-stage data feed to a checker or display block).
- Generalises the fixed 5x2-bit stage mux:
  - parametrised width and channel count;
  - fully clocked;
  - explicit idle/active state;
  - per-channel skip mask;
  - wrap indication;
  - synchronous restart.

---
 rtl/seq_data_mux.sv | 148 ++++++++++++++
 tb/tb_seq_data_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_data_mux.sv
// seq_data_mux -- registered round-robin sequencing multiplexer.
//
// Presents one of NUM_CH packed input channels on a single registered output.
// The selection advances once per rising edge of the slow, clock-synchronous
// `advance` level. When the sequence returns to a lower or equal index, `wrap`
// pulses for one cycle. A synchronous `restart` returns the block to IDLE.
//
// Optional feature (compile-time macro SEQ_DATA_MUX_SKIP_EN):
//   defined   : ch_enable selects which channels are visited.
//   undefined : ch_enable is ignored and every channel is visited in order.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   data_in    in   NUM_CH*DATA_W packed channels (ch i at [i*DATA_W +: DATA_W])
//   ch_enable  in   NUM_CH per-channel visit mask
//   advance    in   step request level; only its rising edge acts
//   restart    in   synchronous return to IDLE (wins over a same-cycle step)
//   cur_data   out  DATA_W registered data of the selected channel
//   cur_idx    out  IDX_W index of the selected channel
//   valid      out  high while ACTIVE
//   wrap       out  one-cycle pulse when the sequence wraps
module seq_data_mux #(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 2,
    parameter int IDX_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   data_in,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic                       advance,
    input  logic                       restart,
    output logic [DATA_W-1:0]          cur_data,
    output logic [IDX_W-1:0]           cur_idx,
    output logic                       valid,
    output logic                       wrap
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                advance_q;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wrap_q, wrap_d;

    logic                adv_rise;
    logic [NUM_CH-1:0]   mask;
    logic                any_en;
    logic                has_after;
    logic [IDX_W-1:0]    low_idx;
    logic [IDX_W-1:0]    after_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic [DATA_W-1:0]   sel_data;

`ifdef SEQ_DATA_MUX_SKIP_EN
    assign mask = ch_enable;
`else
    logic unused_ch_enable;
    assign unused_ch_enable = ^ch_enable;
    assign mask = '1;
`endif

    assign adv_rise = advance & ~advance_q;

    // Scan from the top down so the last hit is the lowest index. The lowest
    // enabled index above cur_idx is the round-robin successor; if there is
    // none, the search wraps to the lowest enabled index overall.
    always_comb begin
        any_en    = 1'b0;
        has_after = 1'b0;
        low_idx   = '0;
        after_idx = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (mask[j]) begin
                any_en  = 1'b1;
                low_idx = IDX_W'(j);
                if (IDX_W'(j) > idx_q) begin
                    has_after = 1'b1;
                    after_idx = IDX_W'(j);
                end
            end
        end
    end

    assign sel_idx = ((state_q == ACTIVE) && has_after) ? after_idx : low_idx;

    always_comb begin
        sel_data = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (IDX_W'(j) == sel_idx) begin
                sel_data = data_in[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wrap_d  = 1'b0;
        if (restart) begin
            state_d = IDLE;
            idx_d   = '0;
            data_d  = '0;
        end else if (adv_rise) begin
            if (!any_en) begin
                // Empty mask: from ACTIVE drop back to IDLE, from IDLE stay put.
                state_d = IDLE;
                idx_d   = '0;
                data_d  = '0;
            end else begin
                state_d = ACTIVE;
                idx_d   = sel_idx;
                data_d  = sel_data;
                // No enabled channel above the current one means we wrapped,
                // including the case where only the current channel is enabled.
                wrap_d  = (state_q == ACTIVE) && !has_after;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            advance_q <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            advance_q <= advance;
            idx_q     <= idx_d;
            data_q    <= data_d;
            wrap_q    <= wrap_d;
        end
    end

    assign cur_data = data_q;
    assign cur_idx  = idx_q;
    assign valid    = (state_q == ACTIVE);
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_seq_data_mux.sv
// tb_seq_data_mux -- self-checking bench for seq_data_mux.
//
// Two instances share clk and reset: a default 5x2-bit instance (A) and an
// 8x8-bit instance (B). A behavioural model tracks both; outputs are compared
// 1 time unit after every rising edge and directly after async reset asserts.
// The model honours ch_enable only when SEQ_DATA_MUX_SKIP_EN is defined.
module tb_seq_data_mux;

    logic        clk = 1'b0;
    logic        reset;

    logic [9:0]  a_din;
    logic [4:0]  a_en;
    logic        a_adv, a_rst;
    logic [1:0]  a_data;
    logic [3:0]  a_idx;
    logic        a_valid, a_wrap;

    logic [63:0] b_din;
    logic [7:0]  b_en;
    logic        b_adv, b_rst;
    logic [7:0]  b_data;
    logic [3:0]  b_idx;
    logic        b_valid, b_wrap;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          act;
        int          idx;
        logic [31:0] data;
        bit          wrap;
        bit          advq;
    } mstate_t;

    mstate_t ma, mb;

    seq_data_mux dut_a (
        .clk(clk), .reset(reset), .data_in(a_din), .ch_enable(a_en),
        .advance(a_adv), .restart(a_rst), .cur_data(a_data), .cur_idx(a_idx),
        .valid(a_valid), .wrap(a_wrap)
    );

    seq_data_mux #(.NUM_CH(8), .DATA_W(8), .IDX_W(4)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_din), .ch_enable(b_en),
        .advance(b_adv), .restart(b_rst), .cur_data(b_data), .cur_idx(b_idx),
        .valid(b_valid), .wrap(b_wrap)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Search modulo n for the first enabled channel strictly after start.
    function automatic int pick(int n, logic [15:0] m, int start);
        for (int k = 1; k <= n; k++) begin
            if (m[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic mstate_t mreset();
        mstate_t r;
        r.act = 0; r.idx = 0; r.data = 0; r.wrap = 0; r.advq = 0;
        return r;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int n, int dw, logic [127:0] din,
                                      logic [15:0] en, bit adv, bit rs);
        mstate_t     r;
        logic [15:0] m;
        int          j;
        r = s;
`ifdef SEQ_DATA_MUX_SKIP_EN
        m = en & 16'((1 << n) - 1);
`else
        m = 16'((1 << n) - 1);
`endif
        r.wrap = 0;
        r.advq = adv;
        if (rs) begin
            r.act = 0; r.idx = 0; r.data = 0;
        end else if (adv && !s.advq) begin
            if (m == 0) begin
                r.act = 0; r.idx = 0; r.data = 0;
            end else begin
                j = pick(n, m, s.act ? s.idx : n - 1);
                r.wrap = s.act && (j <= s.idx);
                r.act  = 1;
                r.idx  = j;
                r.data = 32'(din >> (j * dw)) & ((32'd1 << dw) - 1);
            end
        end
        return r;
    endfunction

    task automatic compare_all();
        chk("a_idx",   32'(a_idx),   32'(ma.idx));
        chk("a_data",  32'(a_data),  ma.data);
        chk("a_valid", 32'(a_valid), 32'(ma.act));
        chk("a_wrap",  32'(a_wrap),  32'(ma.wrap));
        chk("b_idx",   32'(b_idx),   32'(mb.idx));
        chk("b_data",  32'(b_data),  mb.data);
        chk("b_valid", 32'(b_valid), 32'(mb.act));
        chk("b_wrap",  32'(b_wrap),  32'(mb.wrap));
    endtask

    task automatic tick();
        @(posedge clk);
        ma = mstep(ma, 5, 2, 128'(a_din), 16'(a_en), a_adv, a_rst);
        mb = mstep(mb, 8, 8, 128'(b_din), 16'(b_en), b_adv, b_rst);
        #1;
        compare_all();
    endtask

    task automatic pulse_a();
        a_adv = 1'b1; tick();
        a_adv = 1'b0; tick();
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        ma = mreset();
        mb = mreset();
        compare_all();
        #2 reset = 1'b0;
    endtask

    initial begin
        int exp_idx  [6] = '{0, 1, 2, 3, 4, 0};
        int exp_data [6] = '{3, 2, 1, 0, 3, 3};
        int exp_wrap [6] = '{0, 0, 0, 0, 0, 1};

        reset = 1'b1;
        a_din = {2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        a_en  = 5'b11111; a_adv = 0; a_rst = 0;
        b_din = 64'h1716151413121110;
        b_en  = 8'hFF; b_adv = 0; b_rst = 0;
        ma = mreset(); mb = mreset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        #3 reset = 1'b0;

        // Six pulses through all five channels, wrapping on the sixth.
        for (int p = 0; p < 6; p++) begin
            a_adv = 1'b1; tick();
            chk("seq_idx",  32'(a_idx),  32'(exp_idx[p]));
            chk("seq_data", 32'(a_data), 32'(exp_data[p]));
            chk("seq_wrap", 32'(a_wrap), 32'(exp_wrap[p]));
            chk("seq_vld",  32'(a_valid), 32'd1);
            a_adv = 1'b0; tick();
        end

        // Level held high gives a single step.
        a_rst = 1'b1; tick(); a_rst = 1'b0; tick();
        a_adv = 1'b1;
        repeat (10) tick();
        chk("hold_idx", 32'(a_idx), 32'd0);
        a_adv = 1'b0; tick();
        pulse_a();
        chk("hold_next", 32'(a_idx), 32'd1);

        // Mask skip, then empty mask.
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        a_en = 5'b10010;
        repeat (3) pulse_a();
        a_en = 5'b00000;
        pulse_a();
        a_en = 5'b11111;

        // Restart together with a rise at idx 2.
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        repeat (3) pulse_a();
        chk("rs_pre", 32'(a_idx), 32'd2);
        a_adv = 1'b1; a_rst = 1'b1; tick();
        chk("rs_vld", 32'(a_valid), 32'd0);
        chk("rs_idx", 32'(a_idx), 32'd0);
        a_adv = 1'b0; a_rst = 1'b0; tick();
        pulse_a();
        chk("rs_next", 32'(a_data), 32'd3);

        // Async reset at idx 3 with advance held through release.
        repeat (3) pulse_a();
        chk("ar_pre", 32'(a_idx), 32'd3);
        a_adv = 1'b1;
        async_reset();
        tick();
        chk("ar_step_vld", 32'(a_valid), 32'd1);
        chk("ar_step_idx", 32'(a_idx), 32'd0);
        a_adv = 1'b0; tick();

        // Eight-channel instance, data changed between steps.
        for (int p = 0; p < 9; p++) begin
            b_adv = 1'b1; tick();
            b_adv = 1'b0;
            b_din[7:0] = 8'h90 + 8'(p);
            tick();
        end
        chk("b_wrap_data", 32'(b_data), 32'h97);

        // Randomised phase on both instances.
        for (int c = 0; c < 1500; c++) begin
            a_din = 10'($urandom);
            b_din = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) a_adv = ~a_adv;
            if ($urandom_range(0, 2) == 0) b_adv = ~b_adv;
            a_rst = ($urandom_range(0, 24) == 0);
            b_rst = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0)
                a_en = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 7) == 0)
                b_en = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            tick();
            if ($urandom_range(0, 120) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
